// File: rtl/tile_scheduler_pkg.sv
// Shared controller types: layer kinds, scheduler FSM states and the tile command record.
// Widths here are the defaults used by tile_scheduler's PIX_W/CH_W parameters.
package tile_scheduler_pkg;

  localparam int TS_PIX_W = 16;
  localparam int TS_CH_W  = 8;
  localparam int TILE_N_W = 32;

  typedef enum logic [1:0] {
    POINTWISE = 2'd0,
    DEPTHWISE = 2'd1,
    STANDARD  = 2'd2,
    LINEAR    = 2'd3
  } layer_type_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_ISSUE,
    S_WAIT,
    S_ADVANCE,
    S_FINISH
  } ts_state_e;

  typedef struct packed {
    logic [TS_PIX_W-1:0] n_base;
    logic [TS_PIX_W-1:0] n_len;
    logic [TS_CH_W-1:0]  k_base;
    logic [TS_CH_W-1:0]  k_len;
    logic [TS_CH_W-1:0]  d_base;
    logic [TS_CH_W-1:0]  d_len;
    logic                first_d;
    logic                last_d;
  } tile_cmd_t;

  // The calculator may hand over a chunk larger than any pixel offset can express.
  function automatic logic [TS_PIX_W-1:0] clamp_tile_n(input logic [TILE_N_W-1:0] t);
    logic [TS_PIX_W-1:0] r;
    if (|t[TILE_N_W-1:TS_PIX_W]) r = '1;
    else                         r = t[TS_PIX_W-1:0];
    return r;
  endfunction

endpackage

// File: rtl/tile_loop_cnt.sv
// One loop level: base advances by size until base+size reaches limit, then wraps to 0.
// len/is_first/is_last are combinational from the held base; no handshake, base moves only on inc.
module tile_loop_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] size,
  input  logic [W-1:0] limit,
  output logic [W-1:0] base,
  output logic [W-1:0] len,
  output logic         is_first,
  output logic         is_last,
  output logic         wrap
);

  logic [W:0] next_end;
  logic [W:0] remain;

  // One guard bit keeps base+size from wrapping at the top of the range.
  assign next_end = {1'b0, base} + {1'b0, size};
  assign remain   = {1'b0, limit} - {1'b0, base};
  assign is_last  = (next_end >= {1'b0, limit});
  assign is_first = (base == '0);
  assign wrap     = inc && is_last;
  assign len      = ({1'b0, size} < remain) ? size : remain[W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base <= '0;
    end else if (clr) begin
      base <= '0;
    end else if (inc) begin
      base <= is_last ? '0 : next_end[W-1:0];
    end
  end

endmodule

// File: rtl/tile_scheduler.sv
// Walks one layer as n-chunk (outer) x k-tile x d-tile (inner), one command per datapath tile.
// First cmd_valid 2 cycles after start; command held stable under cmd_ready low, next issued after tile_done.
module tile_scheduler
  import tile_scheduler_pkg::*;
#(
  parameter int PIX_W = TS_PIX_W,
  parameter int CH_W  = TS_CH_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       layer_type,
  input  logic [CH_W-1:0]  in_C,
  input  logic [CH_W-1:0]  out_C,
  input  logic [CH_W-1:0]  tile_D,
  input  logic [CH_W-1:0]  tile_K,
  input  logic [31:0]      tile_n,
  input  logic [PIX_W-1:0] num_pix,
  output logic             cmd_valid,
  input  logic             cmd_ready,
  output logic [PIX_W-1:0] cmd_n_base,
  output logic [PIX_W-1:0] cmd_n_len,
  output logic [CH_W-1:0]  cmd_k_base,
  output logic [CH_W-1:0]  cmd_k_len,
  output logic [CH_W-1:0]  cmd_d_base,
  output logic [CH_W-1:0]  cmd_d_len,
  output logic             cmd_first_d,
  output logic             cmd_last_d,
  input  logic             tile_done,
  output logic             busy,
  output logic             done,
  output logic             cfg_err
);

  ts_state_e        state;
  layer_type_e      cfg_type;
  logic [CH_W-1:0]  cfg_in_c;
  logic [CH_W-1:0]  cfg_out_c;
  logic [CH_W-1:0]  cfg_tile_d;
  logic [CH_W-1:0]  cfg_tile_k;
  logic [PIX_W-1:0] cfg_tile_n;
  logic [PIX_W-1:0] cfg_num_pix;

  logic             is_dw;
  logic             cfg_ok;
  logic             cnt_clr;
  logic             adv;
  logic             n_inc, k_inc, d_inc;
  logic             n_wrap, k_wrap, d_wrap;
  logic             n_first, n_last, k_first, k_last, d_first, d_last;
  logic [PIX_W-1:0] n_base, n_len;
  logic [CH_W-1:0]  k_base, k_len, d_base, d_len;
  logic             unused_flags;

  tile_cmd_t        cmd;
  tile_cmd_t        cmd_out;

  assign is_dw   = (cfg_type == DEPTHWISE);
  assign cfg_ok  = (cfg_tile_n != '0) && (cfg_tile_d != '0) && (cfg_tile_k != '0) &&
                   (cfg_num_pix != '0) && (cfg_in_c != '0) && (cfg_out_c != '0);
  assign cnt_clr = (state == S_CHECK);
  assign adv     = (state == S_ADVANCE);

  // Depthwise has no input-channel loop: every ADVANCE steps k directly.
  assign d_inc = adv && !is_dw;
  assign k_inc = is_dw ? adv : d_wrap;
  assign n_inc = k_wrap;

  tile_loop_cnt #(.W(PIX_W)) u_n_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (cnt_clr),
    .inc      (n_inc),
    .size     (cfg_tile_n),
    .limit    (cfg_num_pix),
    .base     (n_base),
    .len      (n_len),
    .is_first (n_first),
    .is_last  (n_last),
    .wrap     (n_wrap)
  );

  tile_loop_cnt #(.W(CH_W)) u_k_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (cnt_clr),
    .inc      (k_inc),
    .size     (cfg_tile_k),
    .limit    (cfg_out_c),
    .base     (k_base),
    .len      (k_len),
    .is_first (k_first),
    .is_last  (k_last),
    .wrap     (k_wrap)
  );

  tile_loop_cnt #(.W(CH_W)) u_d_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (cnt_clr),
    .inc      (d_inc),
    .size     (cfg_tile_d),
    .limit    (cfg_in_c),
    .base     (d_base),
    .len      (d_len),
    .is_first (d_first),
    .is_last  (d_last),
    .wrap     (d_wrap)
  );

  assign unused_flags = ^{n_first, n_last, k_first, k_last};

  always_comb begin
    cmd        = '0;
    cmd.n_base = n_base;
    cmd.n_len  = n_len;
    cmd.k_base = k_base;
    cmd.k_len  = k_len;
    if (is_dw) begin
      cmd.d_base  = k_base;
      cmd.d_len   = k_len;
      cmd.first_d = 1'b1;
      cmd.last_d  = 1'b1;
    end else begin
      cmd.d_base  = d_base;
      cmd.d_len   = d_len;
      cmd.first_d = d_first;
      cmd.last_d  = d_last;
    end
  end

  // Fields read as zero whenever no command is offered, including straight out of reset.
  assign cmd_out     = cmd_valid ? cmd : '0;
  assign cmd_n_base  = cmd_out.n_base;
  assign cmd_n_len   = cmd_out.n_len;
  assign cmd_k_base  = cmd_out.k_base;
  assign cmd_k_len   = cmd_out.k_len;
  assign cmd_d_base  = cmd_out.d_base;
  assign cmd_d_len   = cmd_out.d_len;
  assign cmd_first_d = cmd_out.first_d;
  assign cmd_last_d  = cmd_out.last_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      cfg_type    <= POINTWISE;
      cfg_in_c    <= '0;
      cfg_out_c   <= '0;
      cfg_tile_d  <= '0;
      cfg_tile_k  <= '0;
      cfg_tile_n  <= '0;
      cfg_num_pix <= '0;
      cmd_valid   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            cfg_type    <= layer_type_e'(layer_type);
            cfg_in_c    <= in_C;
            cfg_out_c   <= out_C;
            cfg_tile_d  <= tile_D;
            cfg_tile_k  <= tile_K;
            cfg_tile_n  <= clamp_tile_n(tile_n);
            cfg_num_pix <= num_pix;
            cfg_err     <= 1'b0;
            busy        <= 1'b1;
            state       <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (!cfg_ok) begin
            cfg_err <= 1'b1;
            done    <= 1'b1;
            state   <= S_FINISH;
          end else begin
            cmd_valid <= 1'b1;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (cmd_ready) begin
            cmd_valid <= 1'b0;
            state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (tile_done) state <= S_ADVANCE;
        end
        S_ADVANCE: begin
          // The outer wrap means every loop level has been exhausted.
          if (n_wrap) begin
            done  <= 1'b1;
            state <= S_FINISH;
          end else begin
            cmd_valid <= 1'b1;
            state     <= S_ISSUE;
          end
        end
        S_FINISH: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tile_scheduler.sv
// Bench for tile_scheduler: nested-loop reference list of expected tile commands, scoreboarded per handshake.
module tb_tile_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  layer_type = '0;
  logic [7:0]  in_C = '0, out_C = '0, tile_D = '0, tile_K = '0;
  logic [31:0] tile_n = '0;
  logic [15:0] num_pix = '0;
  logic        cmd_ready = 1'b0;
  logic        tile_done = 1'b0;

  logic        cmd_valid;
  logic [15:0] cmd_n_base, cmd_n_len;
  logic [7:0]  cmd_k_base, cmd_k_len, cmd_d_base, cmd_d_len;
  logic        cmd_first_d, cmd_last_d;
  logic        busy, done, cfg_err;

  tile_scheduler #(.PIX_W(16), .CH_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .layer_type  (layer_type),
    .in_C        (in_C),
    .out_C       (out_C),
    .tile_D      (tile_D),
    .tile_K      (tile_K),
    .tile_n      (tile_n),
    .num_pix     (num_pix),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_n_base  (cmd_n_base),
    .cmd_n_len   (cmd_n_len),
    .cmd_k_base  (cmd_k_base),
    .cmd_k_len   (cmd_k_len),
    .cmd_d_base  (cmd_d_base),
    .cmd_d_len   (cmd_d_len),
    .cmd_first_d (cmd_first_d),
    .cmd_last_d  (cmd_last_d),
    .tile_done   (tile_done),
    .busy        (busy),
    .done        (done),
    .cfg_err     (cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int nb; int nl; int kb; int kl; int db; int dl; int fd; int ld;
  } cmd_s;

  cmd_s exp_q[$];
  cmd_s acc_log[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = -1;
  int first_valid_cyc = -1;
  int start_cyc = 0;
  bit prev_stall = 1'b0;
  logic [65:0] prev_vec = '0;

  always @(posedge clk) cyc++;

  function automatic void chk(input string name, input longint got, input longint want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endfunction

  function automatic void chk_vec(input string name, input logic [65:0] got, input logic [65:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endfunction

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic cmd_s mk(input int nb, nl, kb, kl, db, dl, fd, ld);
    cmd_s c;
    c.nb = nb; c.nl = nl; c.kb = kb; c.kl = kl;
    c.db = db; c.dl = dl; c.fd = fd; c.ld = ld;
    return c;
  endfunction

  function automatic logic [65:0] pk(input cmd_s c);
    logic [15:0] nb, nl;
    logic [7:0]  kb, kl, db, dl;
    nb = 16'(c.nb); nl = 16'(c.nl);
    kb = 8'(c.kb);  kl = 8'(c.kl); db = 8'(c.db); dl = 8'(c.dl);
    return {nb, nl, kb, kl, db, dl, (c.fd != 0), (c.ld != 0)};
  endfunction

  // Expected command sequence: plain nested loops over the layer shape.
  function automatic void build_model(input int lt, ic, oc, td, tk, input longint tn, input int np);
    int tnc;
    exp_q.delete();
    if (tn == 0 || td == 0 || tk == 0 || np == 0 || ic == 0 || oc == 0) return;
    tnc = (tn > 65535) ? 65535 : int'(tn);
    for (int n = 0; n < np; n += tnc)
      for (int k = 0; k < oc; k += tk)
        if (lt == 1)
          exp_q.push_back(mk(n, imin(tnc, np - n), k, imin(tk, oc - k), k, imin(tk, oc - k), 1, 1));
        else
          for (int d = 0; d < ic; d += td)
            exp_q.push_back(mk(n, imin(tnc, np - n), k, imin(tk, oc - k), d, imin(td, ic - d),
                               (d == 0) ? 1 : 0, (d + td >= ic) ? 1 : 0));
  endfunction

  // Compare process: scoreboard on every handshake, stability under stall, done bookkeeping.
  always @(negedge clk) begin
    logic [65:0] cur;
    cmd_s o, e;
    cur = {cmd_n_base, cmd_n_len, cmd_k_base, cmd_k_len, cmd_d_base, cmd_d_len, cmd_first_d, cmd_last_d};
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        chk("busy_at_done", busy, 1);
        chk("queue_empty_at_done", exp_q.size(), 0);
      end
      if (prev_stall) begin
        chk("valid_held", cmd_valid, 1);
        chk_vec("fields_stable", cur, prev_vec);
      end
      if (cmd_valid) begin
        chk("valid_implies_busy", busy, 1);
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
        if (cmd_ready) begin
          o = mk(int'(cmd_n_base), int'(cmd_n_len), int'(cmd_k_base), int'(cmd_k_len),
                 int'(cmd_d_base), int'(cmd_d_len), int'(cmd_first_d), int'(cmd_last_d));
          acc_log.push_back(o);
          if (exp_q.size() == 0) begin
            chk_vec("unexpected_cmd", cur, '0);
          end else begin
            e = exp_q.pop_front();
            chk_vec("cmd", cur, pk(e));
          end
        end
      end
      prev_stall = cmd_valid && !cmd_ready;
      prev_vec   = cur;
    end
  end

  // mode 0: random ready and tile_done delay; mode 1: 5-cycle stall per command plus a stray tile_done in ISSUE.
  task automatic run_layer(input int lt, ic, oc, td, tk, input longint tn, input int np, input int mode);
    int  pend, stall, budget, exp_n;
    bit  hs, exp_err;
    build_model(lt, ic, oc, td, tk, tn, np);
    exp_n   = exp_q.size();
    exp_err = (tn == 0 || td == 0 || tk == 0 || np == 0 || ic == 0 || oc == 0);
    acc_log.delete();
    done_cnt = 0; done_cyc = -1; first_valid_cyc = -1;
    layer_type = 2'(lt); in_C = 8'(ic); out_C = 8'(oc); tile_D = 8'(td); tile_K = 8'(tk);
    tile_n = tn[31:0]; num_pix = 16'(np);
    start = 1'b1; start_cyc = cyc;
    pend = -1; stall = 0; budget = 0;
    while (done_cnt == 0 && budget < 5000) begin
      tile_done = (pend == 0);
      if (pend >= 0) pend--;
      if (cmd_valid) begin
        if (mode == 1 && stall < 5) begin
          cmd_ready = 1'b0;
          if (stall == 1) tile_done = 1'b1;
          stall++;
        end else begin
          cmd_ready = ($urandom_range(99) < 70);
        end
      end else begin
        cmd_ready = 1'($urandom_range(1));
        stall = 0;
      end
      hs = cmd_valid && cmd_ready;
      @(posedge clk); #1;
      if (start) begin
        // Config changes and stray starts after acceptance must not disturb the layer.
        start = 1'b0;
        in_C = 8'($urandom_range(255)); out_C = 8'($urandom_range(255));
        tile_D = 8'($urandom_range(255)); tile_K = 8'($urandom_range(255));
        layer_type = 2'($urandom_range(3));
      end else if (mode == 0) begin
        start = ($urandom_range(19) == 0);
      end
      if (hs) pend = $urandom_range(3);
      budget++;
    end
    start = 1'b0; cmd_ready = 1'b0; tile_done = 1'b0;
    chk("done_seen_in_budget", (done_cnt > 0) ? 1 : 0, 1);
    repeat (3) begin @(posedge clk); #1; end
    chk("done_once", done_cnt, 1);
    chk("busy_after_done", busy, 0);
    chk("cfg_err", cfg_err, exp_err ? 1 : 0);
    chk("cmds_left", exp_q.size(), 0);
    chk("cmd_count", acc_log.size(), exp_n);
    if (exp_err) chk("err_done_latency", done_cyc - start_cyc, 2);
    else         chk("first_valid_latency", first_valid_cyc - start_cyc, 2);
  endtask

  task automatic reset_in_wait();
    int guard;
    logic [75:0] outs;
    build_model(0, 16, 16, 8, 8, 8, 8);
    acc_log.delete();
    layer_type = 2'd0; in_C = 8'd16; out_C = 8'd16; tile_D = 8'd8; tile_K = 8'd8;
    tile_n = 32'd8; num_pix = 16'd8;
    start = 1'b1; cmd_ready = 1'b1; tile_done = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    guard = 0;
    while (cmd_valid !== 1'b1 && guard < 20) begin @(posedge clk); #1; guard++; end
    chk("rst_prep_valid", cmd_valid, 1);
    @(posedge clk); #1;
    cmd_ready = 1'b0;
    chk("wait_valid_low", cmd_valid, 0);
    chk("wait_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    outs = {cmd_valid, cmd_n_base, cmd_n_len, cmd_k_base, cmd_k_len, cmd_d_base, cmd_d_len,
            cmd_first_d, cmd_last_d, busy, done, cfg_err};
    chk("async_reset_outs_zero", (outs == '0) ? 1 : 0, 1);
    chk("async_reset_busy", busy, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    int lt, ic, oc, td, tk, np, z;
    longint tn;

    #12;
    chk("reset_valid", cmd_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_cfg_err", cfg_err, 0);
    chk_vec("reset_fields", {cmd_n_base, cmd_n_len, cmd_k_base, cmd_k_len, cmd_d_base, cmd_d_len,
                             cmd_first_d, cmd_last_d}, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // PW reference layer: 3 chunks x 2 d-tiles.
    run_layer(0, 32, 16, 16, 16, 8, 20, 0);
    chk("pw_count_literal", acc_log.size(), 6);
    if (acc_log.size() == 6) begin
      chk("pw_c0_dlen", acc_log[0].dl, 16);
      chk("pw_c0_first", acc_log[0].fd, 1);
      chk("pw_c0_last", acc_log[0].ld, 0);
      chk("pw_c4_nbase", acc_log[4].nb, 16);
      chk("pw_c4_nlen", acc_log[4].nl, 4);
      chk("pw_c5_dbase", acc_log[5].db, 16);
      chk("pw_c5_last", acc_log[5].ld, 1);
    end

    // DW: d follows k, in_C ignored.
    run_layer(1, 24, 24, 16, 16, 100, 49, 0);
    chk("dw_count_literal", acc_log.size(), 2);
    if (acc_log.size() == 2) begin
      chk("dw_c1_kbase", acc_log[1].kb, 16);
      chk("dw_c1_klen", acc_log[1].kl, 8);
      chk("dw_c1_dbase", acc_log[1].db, 16);
      chk("dw_c1_dlen", acc_log[1].dl, 8);
      chk("dw_c1_flags", acc_log[1].fd + acc_log[1].ld, 2);
      chk("dw_c0_nlen", acc_log[0].nl, 49);
    end

    run_layer(2, 40, 30, 16, 16, 8, 20, 1);
    run_layer(0, 32, 16, 16, 16, 0, 20, 0);

    // Widths at their limits: tile_n clamps to 65535, k tiles 128 then 127.
    run_layer(0, 8, 255, 8, 128, 64'd1048576, 65535, 0);
    chk("wide_count_literal", acc_log.size(), 2);
    if (acc_log.size() == 2) begin
      chk("wide_c0_klen", acc_log[0].kl, 128);
      chk("wide_c1_klen", acc_log[1].kl, 127);
      chk("wide_c0_nlen", acc_log[0].nl, 65535);
      chk("wide_c1_kbase", acc_log[1].kb, 128);
    end

    reset_in_wait();
    run_layer(0, 16, 16, 8, 8, 8, 8, 0);
    if (acc_log.size() > 0)
      chk("restart_origin", acc_log[0].nb + acc_log[0].kb + acc_log[0].db, 0);

    for (int r = 0; r < 15; r++) begin
      lt = $urandom_range(3);
      ic = $urandom_range(40, 1); td = $urandom_range(ic + 4, ic / 3 + 1);
      oc = $urandom_range(40, 1); tk = $urandom_range(oc + 4, oc / 3 + 1);
      np = $urandom_range(60, 1); tn = longint'($urandom_range(np + 4, np / 3 + 1));
      if ($urandom_range(7) == 0) begin
        z = $urandom_range(5);
        case (z)
          0: ic = 0;
          1: oc = 0;
          2: td = 0;
          3: tk = 0;
          4: np = 0;
          default: tn = 0;
        endcase
      end
      run_layer(lt, ic, oc, td, tk, tn, np, r % 2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
